// File: rtl/game_flow_controller.sv
// Round sequencer: menu -> countdown -> fight -> end screen.
// Drives display-mux screen flags and a per-round health reset pulse.
module game_flow_controller #(
    parameter logic [31:0] START_CODE_A = 32'h20DF_5BA4,
    parameter logic [31:0] START_CODE_B = 32'h20DF_5AA5,
    parameter logic [31:0] RESTART_CODE = 32'h20DF_22DD,
    parameter int          COUNT_STEPS  = 3,
    parameter int          COUNT_FRAMES = 60,
    parameter int          END_FRAMES   = 600
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] ir_in,
    input  logic        ir_valid_in,
    input  logic        nf_in,
    input  logic [2:0]  player_health_in,
    input  logic [2:0]  opponent_health_in,
    output logic [2:0]  state_out,
    output logic        display_start_out,
    output logic [1:0]  countdown_out,
    output logic        game_active_out,
    output logic        end_win_out,
    output logic        end_lose_out,
    output logic        end_draw_out,
    output logic        health_reset_out
);

    localparam int MAXF = (COUNT_FRAMES > END_FRAMES) ? COUNT_FRAMES : END_FRAMES;
    localparam int CW   = $clog2(MAXF);
    localparam logic [CW-1:0] CF_LAST = CW'(COUNT_FRAMES - 1);
    localparam logic [CW-1:0] EF_LAST = CW'(END_FRAMES - 1);
    localparam logic [1:0]    CD_INIT = 2'(COUNT_STEPS);

    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_COUNT = 3'd1,
        S_FIGHT = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4,
        S_DRAW  = 3'd5
    } state_t;

    state_t        state_q, state_nx;
    logic [CW-1:0] cnt_q;
    logic [1:0]    cd_q;
    logic          hr_q;
    logic          ds_q, ga_q, win_q, lose_q, draw_q;
    logic          ds_d, ga_d, win_d, lose_d, draw_d;
    logic          start_hit, restart_hit, entry, is_end;

    assign start_hit   = ir_valid_in && (ir_in == START_CODE_A || ir_in == START_CODE_B);
    assign restart_hit = ir_valid_in && (ir_in == RESTART_CODE);
    assign entry       = (state_nx != state_q);
    assign is_end      = (state_q == S_WIN) || (state_q == S_LOSE) || (state_q == S_DRAW);

    // State, counters and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_START;
            cnt_q   <= '0;
            cd_q    <= '0;
            hr_q    <= 1'b0;
            ds_q    <= 1'b1;
            ga_q    <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            draw_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            hr_q    <= entry && (state_nx == S_COUNT);
            ds_q    <= ds_d;
            ga_q    <= ga_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            draw_q  <= draw_d;
            if (entry) begin
                cnt_q <= '0;
                cd_q  <= (state_nx == S_COUNT) ? CD_INIT : 2'd0;
            end else if (nf_in) begin
                if (state_q == S_COUNT) begin
                    if (cnt_q == CF_LAST) begin
                        cnt_q <= '0;
                        cd_q  <= cd_q - 2'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else if (is_end) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_START: if (start_hit) state_nx = S_COUNT;
            S_COUNT: begin
                if (nf_in && cnt_q == CF_LAST && cd_q == 2'd1)
                    state_nx = S_FIGHT;
            end
            S_FIGHT: begin
                if (player_health_in == 3'd0 && opponent_health_in == 3'd0)
                    state_nx = S_DRAW;
                else if (player_health_in == 3'd0)
                    state_nx = S_LOSE;
                else if (opponent_health_in == 3'd0)
                    state_nx = S_WIN;
            end
            S_WIN, S_LOSE, S_DRAW: begin
                // IR commands take priority over the timeout
                if (restart_hit)
                    state_nx = S_COUNT;
                else if (start_hit)
                    state_nx = S_START;
                else if (nf_in && cnt_q == EF_LAST)
                    state_nx = S_START;
            end
            default: state_nx = S_START;
        endcase
    end

    always_comb begin
        ds_d   = (state_nx == S_START);
        ga_d   = (state_nx == S_FIGHT);
        win_d  = (state_nx == S_WIN);
        lose_d = (state_nx == S_LOSE);
        draw_d = (state_nx == S_DRAW);
    end

    assign state_out         = state_q;
    assign display_start_out = ds_q;
    assign countdown_out     = cd_q;
    assign game_active_out   = ga_q;
    assign end_win_out       = win_q;
    assign end_lose_out      = lose_q;
    assign end_draw_out      = draw_q;
    assign health_reset_out  = hr_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Scoreboard bench for game_flow_controller.
// Expected output vectors are queued with stimulus and popped after the edge.
module tb_game_flow_controller;

    localparam logic [31:0] CODE_A  = 32'h20DF_5BA4;
    localparam logic [31:0] CODE_B  = 32'h20DF_5AA5;
    localparam logic [31:0] CODE_RS = 32'h20DF_22DD;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] ir_in = '0;
    logic        ir_valid_in = 1'b0;
    logic        nf_in = 1'b0;
    logic [2:0]  player_health_in = 3'd3;
    logic [2:0]  opponent_health_in = 3'd3;
    logic [2:0]  state_out;
    logic        display_start_out;
    logic [1:0]  countdown_out;
    logic        game_active_out;
    logic        end_win_out;
    logic        end_lose_out;
    logic        end_draw_out;
    logic        health_reset_out;

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    game_flow_controller dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .ir_in              (ir_in),
        .ir_valid_in        (ir_valid_in),
        .nf_in              (nf_in),
        .player_health_in   (player_health_in),
        .opponent_health_in (opponent_health_in),
        .state_out          (state_out),
        .display_start_out  (display_start_out),
        .countdown_out      (countdown_out),
        .game_active_out    (game_active_out),
        .end_win_out        (end_win_out),
        .end_lose_out       (end_lose_out),
        .end_draw_out       (end_draw_out),
        .health_reset_out   (health_reset_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [10:0] exp_v(logic [2:0] s, logic [1:0] cd, logic hr);
        return {s, s == 3'd0, cd, s == 3'd2, s == 3'd3, s == 3'd4, s == 3'd5, hr};
    endfunction

    function automatic logic [10:0] obs_v();
        return {state_out, display_start_out, countdown_out, game_active_out,
                end_win_out, end_lose_out, end_draw_out, health_reset_out};
    endfunction

    task automatic check(string tag, logic [10:0] got, logic [10:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic expect_next(string tag, logic [2:0] s, logic [1:0] cd, logic hr);
        sb.push_back('{tag, exp_v(s, cd, hr)});
    endtask

    task automatic cyc();
        exp_t e;
        @(posedge clk_in);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.tag, obs_v(), e.v);
        end
    endtask

    task automatic nf_pulses(int n);
        for (int i = 0; i < n; i++) begin
            nf_in = 1'b1;
            cyc();
            nf_in = 1'b0;
            cyc();
        end
    endtask

    task automatic strobe_ir(logic [31:0] code, logic with_nf);
        ir_in = code;
        ir_valid_in = 1'b1;
        nf_in = with_nf;
        cyc();
        ir_valid_in = 1'b0;
        nf_in = 1'b0;
    endtask

    task automatic run_countdown();
        nf_pulses(59);
        expect_next("cd_step1", 3'd1, 2'd2, 1'b0);
        nf_pulses(1);
        nf_pulses(119);
        expect_next("cd_last", 3'd1, 2'd1, 1'b0);
        cyc();
        expect_next("fight", 3'd2, 2'd0, 1'b0);
        nf_pulses(1);
    endtask

    initial begin
        expect_next("reset", 3'd0, 2'd0, 1'b0);
        cyc();
        cyc();
        rst_in = 1'b0;
        cyc();

        expect_next("start_a", 3'd1, 2'd3, 1'b1);
        strobe_ir(CODE_A, 1'b0);
        expect_next("hr_pulse_end", 3'd1, 2'd3, 1'b0);
        cyc();
        // CODE_A stays on ir_in with no strobe from here on
        run_countdown();
        expect_next("fight_hold", 3'd2, 2'd0, 1'b0);
        cyc();
        opponent_health_in = 3'd0;
        expect_next("win", 3'd3, 2'd0, 1'b0);
        cyc();
        opponent_health_in = 3'd3;
        nf_pulses(599);
        expect_next("win_599", 3'd3, 2'd0, 1'b0);
        cyc();
        expect_next("win_timeout", 3'd0, 2'd0, 1'b0);
        nf_pulses(1);

        expect_next("ignore_rs", 3'd0, 2'd0, 1'b0);
        strobe_ir(CODE_RS, 1'b0);
        expect_next("start_b_nf", 3'd1, 2'd3, 1'b1);
        strobe_ir(CODE_B, 1'b1);
        run_countdown();
        player_health_in = 3'd0;
        expect_next("lose", 3'd4, 2'd0, 1'b0);
        cyc();
        player_health_in = 3'd3;
        expect_next("rematch", 3'd1, 2'd3, 1'b1);
        strobe_ir(CODE_RS, 1'b0);
        expect_next("rematch_hr_end", 3'd1, 2'd3, 1'b0);
        cyc();

        run_countdown();
        player_health_in = 3'd0;
        opponent_health_in = 3'd0;
        expect_next("draw", 3'd5, 2'd0, 1'b0);
        cyc();
        player_health_in = 3'd3;
        opponent_health_in = 3'd3;
        nf_pulses(599);
        expect_next("draw_ir_wins", 3'd1, 2'd3, 1'b1);
        strobe_ir(CODE_RS, 1'b1);

        nf_pulses(59);
        expect_next("pre_rst", 3'd1, 2'd2, 1'b0);
        nf_pulses(1);
        rst_in = 1'b1;
        nf_in = 1'b1;
        expect_next("rst_mid", 3'd0, 2'd0, 1'b0);
        strobe_ir(CODE_A, 1'b1);
        rst_in = 1'b0;
        expect_next("restart_b", 3'd1, 2'd3, 1'b1);
        strobe_ir(CODE_B, 1'b0);
        cyc();

        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Round sequencer for the FPGA fencing game display path. It takes decoded IR remote codes, new-frame strobes and both players' health. From these it runs the start-menu → countdown → fight → end-screen flow and drives the screen-select flags consumed by the display mux. It also pulses a health reset to the game logic at the start of each round. It sits between the IR decoder / game-state logic and the display module.

## Interface
Parameters:
- START_CODE_A, 32'h20DF_5BA4: IR code that leaves the menu.
- START_CODE_B, 32'h20DF_5AA5: alternate IR code that leaves the menu.
- RESTART_CODE, 32'h20DF_22DD: IR code for a rematch from an end screen.
- COUNT_STEPS, 3: countdown length in steps.
- COUNT_FRAMES, 60: frames per countdown step.
- END_FRAMES, 600: frames an end screen is shown before returning to the menu.

Ports:
- clk_in, input, 1: system clock. The block has one clock. Reset is synchronous and active-high.
- rst_in, input, 1: synchronous, active-high reset.
- ir_in, input, 32: last decoded IR code.
- ir_valid_in, input, 1: one-cycle strobe that marks a newly decoded ir_in.
- nf_in, input, 1: one-cycle new-frame strobe.
- player_health_in, input, 3: player health. 0 means dead.
- opponent_health_in, input, 3: opponent health. 0 means dead.
- state_out, output, 3: current state. START=0, COUNTDOWN=1, FIGHT=2, WIN=3, LOSE=4, DRAW=5.
- display_start_out, output, 1: high while in START.
- countdown_out, output, 2: remaining countdown steps. Nonzero only in COUNTDOWN.
- game_active_out, output, 1: high while in FIGHT.
- end_win_out, end_lose_out, end_draw_out, output, 1 each: high while in WIN, LOSE or DRAW respectively.
- health_reset_out, output, 1: one-cycle pulse on entry to COUNTDOWN.

## Operation
- All outputs are registered and decoded from the state register plus the counters.
- Reset values:
  - state START, display_start_out=1.
  - countdown_out=0, all other outputs 0.
  - Frame counter 0.
- An IR command counts only when ir_valid_in=1 and ir_in matches a code. A held ir_in without a strobe is ignored.
- START: on START_CODE_A or START_CODE_B, go to COUNTDOWN. All other codes are ignored.
- Entry to COUNTDOWN, from any state:
  - countdown_out←COUNT_STEPS, frame counter←0.
  - health_reset_out=1 for exactly one cycle.
- COUNTDOWN, on each nf_in:
  - If counter==COUNT_FRAMES-1: counter←0 and countdown_out decrements.
  - Otherwise counter increments.
  - When countdown_out==1 and the step expires, go to FIGHT with countdown_out←0.
  - IR input is ignored during COUNTDOWN.
  - Health values are ignored during COUNTDOWN (they may still read 0 before the game logic applies the reset).
- FIGHT, checked every cycle:
  - player==0 and opponent≠0: go to LOSE.
  - opponent==0 and player≠0: go to WIN.
  - Both ==0 in the same cycle: go to DRAW.
  - IR input is ignored.
- WIN, LOSE, DRAW:
  - Frame counter←0 on entry. It increments on nf_in.
  - RESTART_CODE strobe: go to COUNTDOWN (rematch).
  - START_CODE_A or START_CODE_B strobe: go to START.
  - Counter reaching END_FRAMES-1 with nf_in: go to START.
  - If an IR command and the timeout fall in the same cycle, the IR command wins.
- Counter width is $clog2(max(COUNT_FRAMES, END_FRAMES)). The counter never wraps, because it is cleared on every state entry.
- States 6 and 7 are unreachable. If the state register ever holds one, the next state is START.

## Timing
- Latency from a triggering input (ir_valid_in, nf_in or a health value) to the new state_out and flags is 1 cycle.
- health_reset_out is high in the same cycle that state_out first reads COUNTDOWN.
- Full countdown duration is COUNT_STEPS×COUNT_FRAMES nf_in pulses:
  - FIGHT is entered the cycle after the final expiring nf_in.
  - With defaults, that is the 180th nf_in after entry.
- Auto-return to START happens the cycle after the END_FRAMES-th nf_in that follows end-state entry.
- rst_in asserted in any state, including mid-countdown, takes effect on the next edge and restores all reset values. rst_in overrides every other input.
- nf_in coinciding with a state entry is not counted.

## Test plan
- Reset, then ir_in=32'h20DF_5BA4 with ir_valid_in for 1 cycle → next cycle state_out=1, countdown_out=3, health_reset_out=1 for 1 cycle, display_start_out=0.
- Countdown: issue 60 nf_in pulses → countdown_out=2. Continue to 180 total → state_out=2, game_active_out=1. A matching ir_in held without a strobe throughout causes no effect.
- FIGHT with player=3, opponent=0 → end_win_out=1 the next cycle. A separate run with player=0, opponent=2 → LOSE. A run with both going 0 in the same cycle → DRAW (state_out=5).
- In LOSE, strobe RESTART_CODE → COUNTDOWN with countdown_out=3 and a health_reset_out pulse. In WIN, 600 nf_in pulses → START with display_start_out=1.
- In DRAW, the 600th nf_in coincides with a RESTART_CODE strobe → COUNTDOWN, not START.
- Assert rst_in in COUNTDOWN at countdown_out=2 → next cycle state START, all outputs at reset values. A following START_CODE_B strobe restarts the countdown from 3.
